top_level: RTL and testbench

TOP_LEVEL -- requirements
Module: top_level

---
 rtl/top_level_pkg.sv | 10 +
 rtl/data_mem.sv | 14 +
 rtl/top_level.sv | 78 +++++++
 tb/tb_top_level.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/top_level_pkg.sv
// top_level_pkg: shared FSM states, memory map and decoder flag encodings
package top_level_pkg;
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, WAIT, FIN} state_t;
    localparam int MSG_COUNT = 15;
    localparam logic [7:0] IN_BASE = 8'd30;
    localparam logic [7:0] OUT_BASE = 8'd0;
    localparam logic [1:0] FLAG_OK = 2'b00;
    localparam logic [1:0] FLAG_SEC = 2'b01;
    localparam logic [1:0] FLAG_DED = 2'b10;
endpackage

// File: rtl/data_mem.sv
// data_mem: 256 x 8 memory, combinational read, synchronous write, never reset
module data_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] core [0:255];
    assign rdata = core[addr];
    // contents deliberately have no reset so preloaded data survives it
    always_ff @(posedge clk)
        if (we) core[addr] <= wdata;
endmodule

// File: rtl/top_level.sv
// top_level: SECDED-decodes 15 words from memory and writes back data plus flags
module top_level
    import top_level_pkg::*;
#(
    parameter int K = 1
) (
    input  logic clk,
    input  logic reset,
    output logic done
);
    localparam logic [3:0] K_LAST = (K > 0) ? 4'(K - 1) : 4'd0;
    localparam logic [3:0] IDX_LAST = 4'(MSG_COUNT - 1);

    state_t      state, next;
    logic [3:0]  idx, cnt;
    logic [15:0] word, res;
    logic [7:0]  addr, wdata, rdata;
    logic        we, last;

    function automatic logic [15:0] decode(input logic [15:0] w);
        logic [3:0]  s;
        logic        p;
        logic [15:0] c;
        logic [1:0]  f;
        s = '0;
        for (int n = 1; n < 16; n++)
            if (w[n]) s ^= 4'(n);
        p = ^w;
        c = p ? w ^ (16'd1 << s) : w;
        f = p ? FLAG_SEC : (s != 4'd0) ? FLAG_DED : FLAG_OK;
        return {f, 3'b000, c[15:9], c[7:5], c[3]};
    endfunction

    data_mem datMem (.clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata));

    assign done = state == FIN;

    // memory port: reads walk the input area, writes walk the output area
    always_comb begin
        addr = ((state == RD_LO || state == RD_HI) ? IN_BASE : OUT_BASE)
             + {3'b000, idx, state == RD_HI || state == WR_HI};
        we = state == WR_LO || state == WR_HI;
        wdata = (state == WR_HI) ? res[15:8] : res[7:0];
    end

    // next state; the end of a message either loops to RD_LO or finishes
    always_comb begin
        last = (state == WR_HI && K == 0) || (state == WAIT && cnt == K_LAST);
        case (state)
            IDLE:    next = RD_LO;
            RD_LO:   next = RD_HI;
            RD_HI:   next = DECODE;
            DECODE:  next = WR_LO;
            WR_LO:   next = WR_HI;
            WR_HI:   next = WAIT;
            default: next = state;
        endcase
        if (last) next = (idx == IDX_LAST) ? FIN : RD_LO;
    end

    // state, message index, idle counter and decode pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            word <= '0;
            res <= '0;
        end else begin
            state <= next;
            cnt <= (state == WAIT) ? cnt + 4'd1 : 4'd0;
            if (state == RD_LO) word[7:0] <= rdata;
            if (state == RD_HI) word[15:8] <= rdata;
            if (state == DECODE) res <= decode(word);
            if (last && idx != IDX_LAST) idx <= idx + 4'd1;
        end
    end
endmodule

// File: tb/tb_top_level.sv
// tb_top_level: directed and randomized checks of the SECDED memory decoder
module tb_top_level;
    import top_level_pkg::*;

    localparam int K = 1;
    localparam int CYC = 15 * (5 + K);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic done;
    int errors = 0;
    int checks = 0;

    logic [7:0]  bg [0:255];
    logic [15:0] vin [15];
    int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [15:0] dir_in [15] = '{16'hFFFF, 16'h0008, 16'h0001, 16'h0006, 16'h0000,
                                 16'hFFFE, 16'hFFF7, 16'h8000, 16'h7FFF, 16'h0018,
                                 16'h0003, 16'h000F, 16'h800F, 16'h022F, 16'h5555};
    logic [15:0] dir_exp [15] = '{16'h07FF, 16'h4000, 16'h4000, 16'h8000, 16'h0000,
                                  16'h47FF, 16'h47FF, 16'h4000, 16'h47FF, 16'h8001,
                                  16'h8000, 16'h0001, 16'h4001, 16'h8013, 16'h02A4};

    top_level #(.K(K)) dut (.clk(clk), .reset(reset), .done(done));

    always #5 clk = ~clk;

    function automatic logic [3:0] syn(input logic [15:0] w);
        return {^(w & 16'hFF00), ^(w & 16'hF0F0), ^(w & 16'hCCCC), ^(w & 16'hAAAA)};
    endfunction

    function automatic logic [15:0] model(input logic [15:0] w);
        logic [3:0]  s;
        logic [15:0] c;
        logic [10:0] d;
        s = syn(w);
        c = w;
        if (^w) c[s] = ~c[s];
        for (int j = 0; j < 11; j++) d[j] = c[pos[j]];
        return {(^w) ? 2'b01 : (s != 4'd0) ? 2'b10 : 2'b00, 3'b000, d};
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        logic [3:0]  s;
        w = '0;
        for (int j = 0; j < 11; j++) w[pos[j]] = d[j];
        s = syn(w);
        w[1] = s[0];
        w[2] = s[1];
        w[4] = s[2];
        w[8] = s[3];
        w[0] = ^w[15:1];
        return w;
    endfunction

    task automatic preload();
        for (int a = 0; a < 256; a++) bg[a] = 8'(a * 7 + 3);
        for (int i = 0; i < 15; i++) begin
            bg[30 + 2 * i] = vin[i][7:0];
            bg[31 + 2 * i] = vin[i][15:8];
        end
        for (int a = 0; a < 256; a++) dut.datMem.core[a] <= bg[a];
        #1;
    endtask

    task automatic run_to_done(output int n);
        n = 0;
        while (!done && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 15; i++) vin[i] = dir_in[i];
        preload();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d, expected IDLE", dut.state); end
        checks++;
        if (dut.idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d, expected 0", dut.idx); end
    endtask

    task automatic test_directed();
        int n, bad;
        logic [15:0] got;
        @(negedge clk);
        reset = 1'b1;
        run_to_done(n);
        checks++;
        if (n !== CYC + 1) begin errors++; $display("FAIL dir_latency: got %0d cycles, expected %0d", n, CYC + 1); end
        for (int i = 0; i < 15; i++) begin
            got = {dut.datMem.core[1 + 2 * i], dut.datMem.core[2 * i]};
            checks++;
            if (got !== dir_exp[i]) begin
                errors++;
                $display("FAIL dir_out[%0d]: in %h got %h, expected %h", i, dir_in[i], got, dir_exp[i]);
            end
        end
        bad = 0;
        for (int a = 30; a < 256; a++) if (dut.datMem.core[a] !== bg[a]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL dir_untouched: %0d bytes in 30..255 changed, expected 0", bad); end
    endtask

    task automatic test_fin_hold();
        dut.datMem.core[0] <= 8'h5C;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL fin_done: got %b, expected 1", done); end
        checks++;
        if (dut.datMem.core[0] !== 8'h5C) begin
            errors++;
            $display("FAIL fin_no_write: core[0] got %h, expected 5c", dut.datMem.core[0]);
        end
    endtask

    task automatic test_mid_reset_random();
        int n, bad, b0, b1;
        logic [15:0] got, w;
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            w = encode(11'($urandom));
            b0 = $urandom_range(0, 15);
            b1 = (b0 + $urandom_range(1, 15)) % 16;
            case (i % 4)
                1: w[b0] = ~w[b0];
                2: begin w[b0] = ~w[b0]; w[b1] = ~w[b1]; end
                3: begin w[b0] = ~w[b0]; w[b0] = ~w[b0]; end
                default: ;
            endcase
            vin[i] = w;
        end
        preload();
        @(negedge clk);
        reset = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        checks++;
        if (dut.idx !== 4'd7) begin errors++; $display("FAIL mid_idx_before: got %0d, expected 7", dut.idx); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b, expected 0", done); end
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("FAIL mid_state: got %0d, expected IDLE", dut.state); end
        checks++;
        if (dut.idx !== 4'd0) begin errors++; $display("FAIL mid_idx: got %0d, expected 0", dut.idx); end
        for (int a = 0; a < 30; a++) dut.datMem.core[a] <= 8'hA5;
        @(negedge clk);
        reset = 1'b1;
        run_to_done(n);
        checks++;
        if (n !== CYC + 1) begin errors++; $display("FAIL mid_latency: got %0d cycles, expected %0d", n, CYC + 1); end
        for (int i = 0; i < 15; i++) begin
            got = {dut.datMem.core[1 + 2 * i], dut.datMem.core[2 * i]};
            checks++;
            if (got !== model(vin[i])) begin
                errors++;
                $display("FAIL rnd_out[%0d]: in %h got %h, expected %h", i, vin[i], got, model(vin[i]));
            end
        end
        bad = 0;
        for (int a = 30; a < 256; a++) if (dut.datMem.core[a] !== bg[a]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL mid_untouched: %0d bytes in 30..255 changed, expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fin_hold();
        test_mid_reset_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
